// File: rtl/gate_check_pkg.sv
// Shared types and defaults for the gate equivalence checker.
package gate_check_pkg;

    localparam int N_IN_DEFAULT   = 3;
    localparam int SETTLE_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that measures how long each stimulus vector is held
// before the gate responses are sampled. It stops at zero.
module settle_timer #(
    parameter int SETTLE_CYC = 1,
    localparam int W = $clog2(SETTLE_CYC) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority over decrement. The counter saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/gate_equiv_checker.sv
// Sweeps every input vector over two gates and compares their responses.
// It counts mismatches and records the first vector that fails.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | after reset; waits for start
//   SETTLE | stim held at vec while the settle timer runs down
//   SAMPLE | compare resp_ref/resp_dut, then advance vec or finish
//   DONE   | results held; start begins a fresh sweep
module gate_equiv_checker
    import gate_check_pkg::*;
#(
    parameter int N_IN       = N_IN_DEFAULT,
    parameter int SETTLE_CYC = SETTLE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            resp_ref,
    input  logic            resp_dut,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_valid
);

    localparam int              TW       = $clog2(SETTLE_CYC) + 1;
    localparam logic [TW-1:0]   RELOAD   = TW'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    state_t          state;
    state_t          state_nxt;
    logic [N_IN-1:0] vec;
    logic            timer_load;
    logic            timer_zero;
    logic            sweep_clr;
    logic            vec_inc;
    logic            sample_en;
    logic            mismatch;

    settle_timer #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (RELOAD),
        .dec      (state == SETTLE),
        .zero     (timer_zero)
    );

    // State register. Reset always returns the FSM to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath strobes. The terminal-vector check comes before the increment, so vec never wraps.
    always_comb begin
        state_nxt  = state;
        timer_load = 1'b0;
        sweep_clr  = 1'b0;
        vec_inc    = 1'b0;
        sample_en  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    sweep_clr  = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_zero) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                sample_en = 1'b1;
                if (vec == VEC_LAST) begin
                    state_nxt = DONE;
                end else begin
                    vec_inc    = 1'b1;
                    timer_load = 1'b1;
                    state_nxt  = SETTLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector counter. It drives stim directly, so stim is registered and glitch-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec <= '0;
        end else if (sweep_clr) begin
            vec <= '0;
        end else if (vec_inc) begin
            vec <= vec + N_IN'(1);
        end
    end

    assign mismatch = resp_ref ^ resp_dut;

    // Mismatch tally and first-failure capture. A zero count marks the first failing vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_count   <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (sweep_clr) begin
            mismatch_count   <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else if (sample_en && mismatch) begin
            mismatch_count <= mismatch_count + (N_IN + 1)'(1);
            if (mismatch_count == '0) begin
                first_fail       <= vec;
                first_fail_valid <= 1'b1;
            end
        end
    end

    assign stim = vec;
    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);
    assign pass = done && (mismatch_count == '0);

endmodule

// File: tb/tb_gate_equiv_checker.sv
// Directed bench: a default 3-input checker against a NAND3 / NAND2-tree pair,
// and a 2-input checker with a longer settle time.
module tb_gate_equiv_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // ---------------- instance A: N_IN=3, SETTLE_CYC=1 ----------------
    logic       start_a = 1'b0;
    logic [2:0] stim_a;
    logic       ref_a, dut_a, impl_a, n1_a, n2_a;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic [3:0] cnt_a;
    logic [2:0] ff_a;
    int         mode_a = 0;

    // Reference NAND3 and an equivalent tree of NAND2 gates, plus fault modes
    assign ref_a  = ~&stim_a;
    assign n1_a   = ~(stim_a[2] & stim_a[1]);
    assign n2_a   = ~(n1_a & n1_a);
    assign impl_a = ~(n2_a & stim_a[0]);
    assign dut_a  = (mode_a == 1) ? (impl_a ^ (stim_a == 3'd5)) :
                    (mode_a == 2) ? ~impl_a : impl_a;

    gate_equiv_checker u_dut_a (
        .clk              (clk),
        .rst              (rst),
        .start            (start_a),
        .stim             (stim_a),
        .resp_ref         (ref_a),
        .resp_dut         (dut_a),
        .busy             (busy_a),
        .done             (done_a),
        .pass             (pass_a),
        .mismatch_count   (cnt_a),
        .first_fail       (ff_a),
        .first_fail_valid (ffv_a)
    );

    // ---------------- instance B: N_IN=2, SETTLE_CYC=3 ----------------
    logic       start_b = 1'b0;
    logic [1:0] stim_b;
    logic       ref_b, dut_b;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [2:0] cnt_b;
    logic [1:0] ff_b;
    int         mode_b = 0;

    assign ref_b = ~&stim_b;
    assign dut_b = ~(stim_b[1] & stim_b[0]) ^ ((mode_b == 1) && (stim_b == 2'd3));

    gate_equiv_checker #(
        .N_IN       (2),
        .SETTLE_CYC (3)
    ) u_dut_b (
        .clk              (clk),
        .rst              (rst),
        .start            (start_b),
        .stim             (stim_b),
        .resp_ref         (ref_b),
        .resp_dut         (dut_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .mismatch_count   (cnt_b),
        .first_fail       (ff_b),
        .first_fail_valid (ffv_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full sweep on instance A. If repulse is between 1 and 16, start is raised again before that edge.
    task automatic sweep_a(input int m, input int repulse, input int exp_cnt,
                           input int exp_ff, input int exp_ffv);
        mode_a = m;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("a_busy_e0", busy_a, 1);
        check("a_stim_e0", stim_a, 0);
        check("a_done_e0", done_a, 0);
        for (int k = 1; k <= 16; k++) begin
            if (k == repulse) start_a = 1'b1;
            @(posedge clk);
            #1;
            start_a = 1'b0;
            if (k < 16) begin
                check("a_stim_step", stim_a, k >> 1);
                check("a_busy_mid", busy_a, 1);
                check("a_done_mid", done_a, 0);
            end else begin
                check("a_done_end", done_a, 1);
                check("a_busy_end", busy_a, 0);
                check("a_stim_end", stim_a, 7);
                check("a_count", cnt_a, exp_cnt);
                check("a_first_fail", ff_a, exp_ff);
                check("a_ff_valid", ffv_a, exp_ffv);
                check("a_pass", pass_a, (exp_cnt == 0) ? 1 : 0);
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("a_done_held", done_a, 1);
        check("a_count_held", cnt_a, exp_cnt);
    endtask

    // Full sweep on instance B. Each vector lasts four cycles.
    task automatic sweep_b(input int m, input int exp_cnt, input int exp_ff, input int exp_ffv);
        mode_b = m;
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        check("b_busy_e0", busy_b, 1);
        check("b_stim_e0", stim_b, 0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k < 16) begin
                check("b_stim_step", stim_b, k >> 2);
                check("b_busy_mid", busy_b, 1);
                check("b_done_mid", done_b, 0);
            end else begin
                check("b_done_end", done_b, 1);
                check("b_busy_end", busy_b, 0);
                check("b_stim_end", stim_b, 3);
                check("b_count", cnt_b, exp_cnt);
                check("b_first_fail", ff_b, exp_ff);
                check("b_ff_valid", ffv_b, exp_ffv);
                check("b_pass", pass_b, (exp_cnt == 0) ? 1 : 0);
            end
        end
    endtask

    initial begin
        #12;
        check("rst_stim", stim_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_pass", pass_a, 0);
        check("rst_count", cnt_a, 0);
        check("rst_ffv", ffv_a, 0);
        check("rst_b_busy", busy_b, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_busy", busy_a, 0);
        check("idle_done", done_a, 0);

        // Correct pair, then a single mismatch at 5, then every vector mismatching
        sweep_a(0, 0, 0, 0, 0);
        sweep_a(1, 0, 1, 5, 1);
        sweep_a(2, 0, 8, 0, 1);
        // start raised again mid-sweep must be ignored
        sweep_a(1, 6, 1, 5, 1);

        // Reset while stim=3, with three mismatches already counted
        mode_a = 2;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_stim", stim_a, 3);
        check("pre_rst_count", cnt_a, 3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_stim", stim_a, 0);
        check("arst_busy", busy_a, 0);
        check("arst_done", done_a, 0);
        check("arst_pass", pass_a, 0);
        check("arst_count", cnt_a, 0);
        check("arst_ff", ff_a, 0);
        check("arst_ffv", ffv_a, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep_a(0, 0, 0, 0, 0);

        // Two-input checker, longer settle, then a failure on the last vector
        sweep_b(0, 0, 0, 0);
        sweep_b(1, 1, 3, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
